// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_MULU = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
// The first iteration runs in the start cycle, so done is high WIDTH-1 cycles after start.
module alu_muldiv_iter #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q, mq_q, b_q;
    logic             div_q, running_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] acc_cur, mq_cur, b_cur;
    logic             div_cur;
    logic [WIDTH:0]   sum, shifted;
    logic [WIDTH-1:0] acc_n, mq_n;

    // Start seeds the step logic straight from the operand ports.
    always_comb begin
        acc_cur = start ? '0     : acc_q;
        mq_cur  = start ? a      : mq_q;
        b_cur   = start ? b      : b_q;
        div_cur = start ? is_div : div_q;
        sum     = {1'b0, acc_cur} + (mq_cur[0] ? {1'b0, b_cur} : '0);
        shifted = {acc_cur, mq_cur[WIDTH-1]};
        acc_n   = sum[WIDTH:1];
        mq_n    = {sum[0], mq_cur[WIDTH-1:1]};
        if (div_cur) begin
            if (shifted >= {1'b0, b_cur}) begin
                acc_n = shifted[WIDTH-1:0] - b_cur;
                mq_n  = {mq_cur[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = shifted[WIDTH-1:0];
                mq_n  = {mq_cur[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            mq_q      <= '0;
            b_q       <= '0;
            div_q     <= 1'b0;
            running_q <= 1'b0;
            cnt_q     <= '0;
        end else if (start) begin
            acc_q     <= acc_n;
            mq_q      <= mq_n;
            b_q       <= b;
            div_q     <= is_div;
            running_q <= 1'b1;
            cnt_q     <= '0;
        end else if (running_q) begin
            if (cnt_q == LAST) begin
                running_q <= 1'b0;
            end else begin
                acc_q <= acc_n;
                mq_q  <= mq_n;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign done = running_q && (cnt_q == LAST);
    assign hi   = acc_q;
    assign lo   = mq_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops plus iterative MULU/DIVU behind a valid/ready pair.
// Handshake: a transfer happens on a clock edge where valid && ready; ready never depends on valid.
module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam logic [SHW:0] WIDTH_EXT = (SHW + 1)'(WIDTH);

    alu_state_e state_q, state_d;

    logic             accept, start_iter, iter_done, big_shift;
    logic [WIDTH-1:0] iter_hi, iter_lo;
    logic [WIDTH-1:0] add_r, sub_r, c_lo, c_hi;
    logic             c_ovf, c_err;

    assign accept     = in_valid && in_ready;
    assign start_iter = accept && ((op == OP_MULU) || (op == OP_DIVU && b_in != '0));
    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (start_iter),
        .is_div (op == OP_DIVU),
        .a      (a_in),
        .b      (b_in),
        .done   (iter_done),
        .hi     (iter_hi),
        .lo     (iter_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = start_iter ? ST_BUSY : ST_DONE;
            ST_BUSY: if (iter_done) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Single-cycle results; divide-by-zero also resolves here without iterating.
    always_comb begin
        add_r     = a_in + b_in;
        sub_r     = a_in - b_in;
        big_shift = ({1'b0, shamt} >= WIDTH_EXT);
        c_lo      = '0;
        c_hi      = '0;
        c_ovf     = 1'b0;
        c_err     = 1'b0;
        case (op)
            OP_ADD: begin
                c_lo  = add_r;
                c_ovf = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (add_r[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_SUB: begin
                c_lo  = sub_r;
                c_ovf = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (sub_r[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_AND:  c_lo = a_in & b_in;
            OP_OR:   c_lo = a_in | b_in;
            OP_NOR:  c_lo = ~(a_in | b_in);
            OP_XOR:  c_lo = a_in ^ b_in;
            OP_SLT:  c_lo = {{(WIDTH-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
            OP_SLTU: c_lo = {{(WIDTH-1){1'b0}}, (a_in < b_in)};
            OP_SLL:  c_lo = big_shift ? '0 : (a_in << shamt);
            OP_SRL:  c_lo = big_shift ? '0 : (a_in >> shamt);
            OP_SRA:  c_lo = big_shift ? {WIDTH{a_in[WIDTH-1]}} : WIDTH'($signed(a_in) >>> shamt);
            OP_DIVU: begin
                c_lo  = '1;
                c_hi  = a_in;
                c_err = 1'b1;
            end
            default: c_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_lo <= '0;
            res_hi <= '0;
            zero   <= 1'b1;
            ovf    <= 1'b0;
            err    <= 1'b0;
        end else if (state_q == ST_IDLE && accept && !start_iter) begin
            res_lo <= c_lo;
            res_hi <= c_hi;
            zero   <= (c_lo == '0);
            ovf    <= c_ovf;
            err    <= c_err;
        end else if (state_q == ST_BUSY && iter_done) begin
            res_lo <= iter_lo;
            res_hi <= iter_hi;
            zero   <= (iter_lo == '0);
            ovf    <= 1'b0;
            err    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: drivers push expected results, a monitor pops them on each output handshake.
module tb_alu_seq;

    localparam int W   = 8;
    localparam int SHW = $clog2(W);
    localparam int EW  = 2*W + 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, out_valid, out_ready;
    logic [3:0]     op;
    logic [W-1:0]   a_in, b_in, res_lo, res_hi;
    logic [SHW-1:0] shamt;
    logic           zero, ovf, err;

    logic [EW-1:0]  exp_q[$];
    int             checks = 0;
    int             failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a_in(a_in), .b_in(b_in), .shamt(shamt), .out_valid(out_valid),
        .out_ready(out_ready), .res_lo(res_lo), .res_hi(res_hi), .zero(zero),
        .ovf(ovf), .err(err)
    );

    function automatic logic [EW-1:0] pk(input logic [W-1:0] lo, input logic [W-1:0] hi,
                                         input logic z, input logic o, input logic e);
        return {lo, hi, z, o, e};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(res_lo), 64'hDEAD);
            end else begin
                check("result", 64'({res_lo, res_hi, zero, ovf, err}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", 64'(in_ready), 64'd1);
    endtask

    // Issue one op from IDLE; return once out_valid is observed, checking latency and stall.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [SHW-1:0] sh, input logic [EW-1:0] exp, input int exp_lat);
        int lat, busy_lo;
        exp_q.push_back(exp);
        op = o; a_in = a; b_in = b; shamt = sh; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 4'd0; a_in = '0; b_in = '0; shamt = '0;
        lat = 1;
        busy_lo = 0;
        while (!out_valid && lat < 40) begin
            if (!in_ready) busy_lo++;
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("latency_op%0d", o), 64'(lat), 64'(exp_lat));
        check($sformatf("stall_op%0d", o), 64'(busy_lo), 64'(exp_lat - 1));
    endtask

    task automatic run(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [SHW-1:0] sh, input logic [EW-1:0] exp, input int exp_lat);
        issue(o, a, b, sh, exp, exp_lat);
        @(posedge clk); #1;
        wait_idle();
    endtask

    initial begin
        int vcnt;
        logic [W-1:0] held_lo;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a_in = '0; b_in = '0; shamt = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_outputs", 64'({res_lo, res_hi, zero, ovf, err}), 64'(pk(8'h00, 8'h00, 1, 0, 0)));
        rst = 1'b0;
        @(posedge clk); #1;

        run(4'd0,  8'h7F, 8'h01, 3'd0, pk(8'h80, 8'h00, 0, 1, 0), 1);
        run(4'd7,  8'h05, 8'h05, 3'd0, pk(8'h00, 8'h00, 1, 0, 0), 1);
        run(4'd4,  8'hFF, 8'h01, 3'd0, pk(8'h01, 8'h00, 0, 0, 0), 1);
        run(4'd8,  8'hFF, 8'h01, 3'd0, pk(8'h00, 8'h00, 1, 0, 0), 1);
        run(4'd9,  8'h90, 8'h00, 3'd3, pk(8'hF2, 8'h00, 0, 0, 0), 1);
        run(4'd5,  8'h81, 8'h00, 3'd1, pk(8'h02, 8'h00, 0, 0, 0), 1);
        run(4'd6,  8'h81, 8'h00, 3'd4, pk(8'h08, 8'h00, 0, 0, 0), 1);
        run(4'd1,  8'hF0, 8'h3C, 3'd0, pk(8'h30, 8'h00, 0, 0, 0), 1);
        run(4'd2,  8'hF0, 8'h0F, 3'd0, pk(8'hFF, 8'h00, 0, 0, 0), 1);
        run(4'd3,  8'hF0, 8'h0F, 3'd0, pk(8'h00, 8'h00, 1, 0, 0), 1);
        run(4'd10, 8'hAA, 8'hFF, 3'd0, pk(8'h55, 8'h00, 0, 0, 0), 1);
        run(4'd7,  8'h80, 8'h01, 3'd0, pk(8'h7F, 8'h00, 0, 1, 0), 1);
        run(4'd0,  8'hFF, 8'h01, 3'd0, pk(8'h00, 8'h00, 1, 0, 0), 1);
        run(4'd11, 8'hFF, 8'hFF, 3'd0, pk(8'h01, 8'hFE, 0, 0, 0), 9);
        run(4'd11, 8'h0D, 8'h0B, 3'd0, pk(8'h8F, 8'h00, 0, 0, 0), 9);
        run(4'd12, 8'd200, 8'd7, 3'd0, pk(8'd28, 8'd4, 0, 0, 0), 9);
        run(4'd12, 8'h33, 8'h00, 3'd0, pk(8'hFF, 8'h33, 0, 0, 1), 1);
        run(4'd12, 8'h05, 8'h09, 3'd0, pk(8'h00, 8'h05, 1, 0, 0), 9);
        run(4'd13, 8'h12, 8'h34, 3'd0, pk(8'h00, 8'h00, 1, 0, 1), 1);

        // Backpressure: result held for 5 cycles while a second request waits.
        out_ready = 1'b0;
        issue(4'd0, 8'h03, 8'h04, 3'd0, pk(8'h07, 8'h00, 0, 0, 0), 1);
        held_lo = res_lo;
        exp_q.push_back(pk(8'hFF, 8'h00, 0, 0, 0));
        op = 4'd2; a_in = 8'hF0; b_in = 8'h0F; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_res_lo", 64'(res_lo), 64'(held_lo));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_after_hs", 64'({in_ready, out_valid}), 64'b10);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_second_done", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        wait_idle();

        // Reset during BUSY cycle 4 of a MULU aborts it silently.
        op = 4'd11; a_in = 8'hFF; b_in = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_before_rst", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_handshake", 64'({in_ready, out_valid}), 64'b10);
        check("abort_outputs", 64'({res_lo, res_hi, zero, ovf, err}), 64'(pk(8'h00, 8'h00, 1, 0, 0)));
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) vcnt++;
        end
        check("abort_no_valid", 64'(vcnt), 64'd0);
        run(4'd14, 8'h55, 8'h66, 3'd0, pk(8'h00, 8'h00, 1, 0, 1), 1);

        repeat (2) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
